// File: rtl/seq_detector_moore_if.sv
// Serial-detector bus: sample strobe, data bit, pattern reload, and Moore match/count results.
interface seq_detector_moore_if #(
  parameter int PATTERN_W = 4,
  parameter int CNT_W     = 8
);
  logic                 en;
  logic                 inp;
  logic                 pat_load;
  logic [PATTERN_W-1:0] pat_in;
  logic                 outp;
  logic [CNT_W-1:0]     match_cnt;

  modport master (output en, inp, pat_load, pat_in, input outp, match_cnt);
  modport slave  (input en, inp, pat_load, pat_in, output outp, match_cnt);
endinterface

// File: rtl/seq_detector_moore.sv
// Moore serial pattern detector with KMP fallback; outp is registered and rises the cycle after the last bit, one bit per en, no backpressure.
// Macro SEQ_DET_COUNT_EN builds the saturating match counter; without it match_cnt is tied to 0.
module seq_detector_moore #(
  parameter int                   PATTERN_W = 4,
  parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1011,
  parameter bit                   OVERLAP   = 1'b1,
  parameter int                   CNT_W     = 8
) (
  input logic            clk,
  input logic            rst,
  seq_detector_moore_if.slave bus
);

  localparam int SW = $clog2(PATTERN_W + 1);
  localparam int HW = PATTERN_W + 1;
  localparam logic [SW-1:0] MATCH = SW'(PATTERN_W);

  logic [PATTERN_W-1:0] pat_q;
  logic [SW-1:0]        state_q;
  logic [SW-1:0]        state_d;
  logic                 outp_q;

  int                   k;
  logic [HW-1:0]        hist;
  logic [HW-1:0]        msk;
  logic [HW-1:0]        pre;

  // The matched history is always the first k pattern bits, so the fallback is
  // the longest pattern prefix that equals a suffix of {prefix(k), inp}.
  always_comb begin
    k       = (state_q == MATCH && !OVERLAP) ? 0 : int'(state_q);
    hist    = ((HW'(pat_q) >> (PATTERN_W - k)) << 1) | HW'(bus.inp);
    msk     = '0;
    pre     = '0;
    state_d = '0;
    for (int j = 1; j <= PATTERN_W; j++) begin
      msk = (HW'(1) << j) - HW'(1);
      pre = HW'(pat_q) >> (PATTERN_W - j);
      if ((j <= k + 1) && ((hist & msk) == pre)) begin
        state_d = SW'(j);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_q   <= PATTERN;
      state_q <= '0;
      outp_q  <= 1'b0;
    end else if (bus.pat_load) begin
      pat_q   <= bus.pat_in;
      state_q <= '0;
      outp_q  <= 1'b0;
    end else if (bus.en) begin
      state_q <= state_d;
      outp_q  <= (state_d == MATCH);
    end
  end

  assign bus.outp = outp_q;

`ifdef SEQ_DET_COUNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (!bus.pat_load && bus.en && (state_d == MATCH) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.match_cnt = cnt_q;
`else
  assign bus.match_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: doc/seq_detector_moore.md
Name: seq_detector_moore

Overview:
- Parametrised Moore-type serial sequence detector, one bit per enabled clock.
- Target pattern width is a parameter; the pattern can be reloaded at run time.
- Overlapping or non-overlapping detection is selectable by parameter.
- Generalises the fixed-pattern single-bit FSM_Moore detector used in the lab designs; adds an optional saturating match counter.

Parameters:
- PATTERN_W, 4, pattern length in bits; legal range 2..16.
- PATTERN, 4'b1011, reset/default pattern; MSB is the first bit received.
- OVERLAP, 1, 1 = overlapping detection, 0 = restart after each match.
- CNT_W, 8, match counter width; legal range 1..16.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset. Asserting rst=0 resets the block immediately; release is synchronous to clk.
- en  input  1  sample strobe; inp is consumed only on a clk edge with en=1.
- inp  input  1  serial data bit.
- pat_load  input  1  load pat_in into the pattern register.
- pat_in  input  PATTERN_W  new pattern; MSB is matched first.
- outp  output  1  Moore match flag; high while the state equals MATCH.
- match_cnt  output  CNT_W  saturating count of matches.

Behaviour:
- States S0..S(PATTERN_W): state index = number of pattern prefix bits currently matched. MATCH = S(PATTERN_W).
- State register width: $clog2(PATTERN_W+1).
- Reset (rst=0, async):
  - state=S0, outp=0, match_cnt=0.
  - Pattern register = PATTERN.
- Priority at each clk edge: pat_load > en > hold.
- pat_load=1:
  - Pattern register <= pat_in; state <= S0; en and inp are ignored that cycle.
  - match_cnt is unchanged.
  - Detection with the new pattern starts on the next enabled bit.
- en=0, pat_load=0: state, outp and match_cnt all hold. outp stays high if already in MATCH.
- en=1, from state Sk with k<PATTERN_W:
  - If inp equals pattern bit [PATTERN_W-1-k], next state is S(k+1).
  - Otherwise, the next state is the longest proper prefix of the pattern that equals a suffix of (matched k bits followed by inp). This is a KMP fallback, computed combinationally against the current pattern register and possibly S0.
- en=1, from MATCH:
  - OVERLAP=1: apply the same fallback rule, treating the history as the full pattern followed by inp. The result may be MATCH again, e.g. pattern 1111.
  - OVERLAP=0: process inp as if the state were S0. The result is S1 or S0; MATCH is never re-entered directly.
- outp = (state == MATCH), registered Moore output with no combinational path from inp.
- Latency: outp rises on the clk edge that samples the last pattern bit, i.e. it is visible in the cycle after that bit was presented.
- match_cnt increments by 1 on every enabled edge whose next state is MATCH, including MATCH→MATCH with OVERLAP=1. It saturates at 2^CNT_W-1 and never wraps.
- Reset mid-sequence discards partial matches; the pattern reverts to PATTERN.
- X on inp while en=0 must not propagate into the state.

Optional Feature:
- Macro: SEQ_DET_COUNT_EN.
- Defined: match_cnt is implemented as described above.
- Not defined:
  - No counter flops are built; match_cnt is tied to 0.
  - Port list is unchanged.
  - All other behaviour is identical.

Test Plan:
1. Basic match, 1011 overlap:
   - Stimulus: defaults; after reset, en=1, stream inp = 1,0,1,1,0,1,1.
   - Response: outp high only in the cycle after bit 4 and the cycle after bit 7; match_cnt=2.
2. Non-overlap mode:
   - Stimulus: OVERLAP=0, same stream as test 1.
   - Response: outp high only after bit 4; match_cnt=1.
   - Then stream 1,0,1,1 → second match; match_cnt=2.
3. Fallback correctness:
   - Stimulus: pattern 1011, stream 1,0,1,0,1,1.
   - Response: states S1,S2,S3,S2,S3,MATCH; outp high after bit 6.
4. Pattern reload and en gating:
   - Stimulus: mid-stream, pat_load=1 with pat_in=4'b1111, in the same cycle as en=1 and inp=1 → state S0.
   - Stream 1,1,1,1,1 → matches after bits 4 and 5; match_cnt increases by 2.
   - Hold en=0 for 3 cycles in MATCH → outp stays 1 and the count is unchanged.
5. Counter saturation:
   - Stimulus: CNT_W=2, pattern 1111, overlap, stream 8 ones.
   - Response: match_cnt goes 1,2,3,3,3; outp stays high from bit 4 onward.
6. Async reset:
   - Stimulus: drive rst=0 between clock edges while in S3 with match_cnt=2.
   - Response: outp=0, match_cnt=0 and state S0 immediately, before the next clk edge.
   - After release, the pattern is back to 1011.
   - Also rebuild without SEQ_DET_COUNT_EN: match_cnt stays 0 throughout tests 1–5.
